simplerisc_inst_encoder: RTL

- Encoder side of the SimpleRISC instruction format: accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit instruction words.
- Buffers encoded words in a small FIFO and streams them into instruction-memory write port at an auto-incrementing address.
- Used by the program loader/self-test path to build instruction memory images that the control decoder later consumes.

---
 rtl/simplerisc_inst_encoder_if.sv | 33 +++
 rtl/simplerisc_inst_encoder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/simplerisc_inst_encoder_if.sv
`default_nettype none
// simplerisc_inst_encoder_if: instruction-field input handshake plus instruction-memory write port.
interface simplerisc_inst_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_opcode;
  logic              in_imm_sel;
  logic [3:0]        in_rd;
  logic [3:0]        in_rs1;
  logic [3:0]        in_rs2;
  logic [1:0]        in_mod;
  logic [15:0]       in_imm;
  logic [26:0]       in_offset;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport master (
    output in_valid, in_opcode, in_imm_sel, in_rd, in_rs1, in_rs2,
           in_mod, in_imm, in_offset, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_opcode, in_imm_sel, in_rd, in_rs1, in_rs2,
           in_mod, in_imm, in_offset, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/simplerisc_inst_encoder.sv
`default_nettype none
// simplerisc_inst_encoder: packs SimpleRISC fields into 32-bit words, FIFOs them, streams them to imem.
// Optional: define ENC_ILLEGAL_TRAP_EN to drop opcodes 10101-11111 and raise err_illegal.
module simplerisc_inst_encoder #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic                    finish,
  simplerisc_inst_encoder_if.slave bus,
  output logic [ADDR_W:0]         word_count,
  output logic                    done,
  output logic                    err_illegal
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_fifo [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W:0]    r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_wcount;
  logic              w_full;
  logic              w_head_valid;
  logic              w_in_ready;
  logic              w_done;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [31:0]       w_word;

  assign w_full       = (r_count == (PTR_W+1)'(DEPTH));
  assign w_head_valid = (r_count != '0);
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_pop        = w_head_valid && bus.mem_ready;

`ifdef ENC_ILLEGAL_TRAP_EN
  logic w_illegal;
  logic r_err;
  assign w_illegal   = (bus.in_opcode >= 5'b10101);
  assign w_push      = w_accept && !w_illegal;
  assign err_illegal = r_err;
`else
  assign w_push      = w_accept;
  assign err_illegal = 1'b0;
`endif

  // Field packing; forced-zero fields and the forced I bit for ld/st are applied here.
  always_comb begin
    w_word = '0;
    unique casez (bus.in_opcode)
      5'b100??: w_word = {bus.in_opcode, bus.in_offset};
      5'b10100,
      5'b01101: w_word = {bus.in_opcode, 27'd0};
      5'b0111?: w_word = {bus.in_opcode, 1'b1, bus.in_rd, bus.in_rs1, bus.in_mod, bus.in_imm};
      default: begin
        w_word[31:27] = bus.in_opcode;
        w_word[26]    = bus.in_imm_sel;
        w_word[25:22] = (bus.in_opcode == 5'b00101) ? 4'd0 : bus.in_rd;
        w_word[21:18] = (bus.in_opcode[4:1] == 4'b0100) ? 4'd0 : bus.in_rs1;
        if (bus.in_imm_sel) begin
          w_word[17:0] = {bus.in_mod, bus.in_imm};
        end else begin
          w_word[17:0] = {bus.in_rs2, 14'd0};
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_in_ready = !w_full;
        if (finish) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!w_head_valid) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= w_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_addr   <= '0;
      r_wcount <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr   <= r_rptr + 1'b1;
        r_addr   <= r_addr + 1'b1;
        r_wcount <= r_wcount + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // FIFO is always empty in IDLE, so start never races a pop.
      if (r_state == S_IDLE && start) begin
        r_addr   <= base_addr;
        r_wcount <= '0;
      end
    end
  end

`ifdef ENC_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_err <= 1'b0;
    end else if (w_accept && w_illegal) begin
      r_err <= 1'b1;
    end
  end
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_we    = w_head_valid;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = w_head_valid ? r_fifo[r_rptr] : 32'd0;
  assign word_count    = r_wcount;
  assign done          = w_done;

endmodule
`default_nettype wire
